// File: rtl/scan_decoder_pkg.sv
// scan_decoder_pkg: shared types and helpers for scan_decoder.
//   state_e   : FSM state encoding (OFF, DIRECT, SCAN_HOLD, SCAN_BLANK)
//   onehot_n  : active-low one-hot of idx over n outputs, all 1s if idx >= n
package scan_decoder_pkg;

  typedef enum logic [1:0] {
    ST_OFF        = 2'd0,
    ST_DIRECT     = 2'd1,
    ST_SCAN_HOLD  = 2'd2,
    ST_SCAN_BLANK = 2'd3
  } state_e;

  // Widest decode the helper supports; callers slice the low NUM_OUT bits.
  localparam int unsigned ONEHOT_MAX_W = 32;

  function automatic logic [ONEHOT_MAX_W-1:0] onehot_n(input int unsigned idx,
                                                       input int unsigned n);
    logic [ONEHOT_MAX_W-1:0] r;
    r = '1;
    // idx < n <= 32, so the low 5 bits address the vector.
    if (idx < n && idx < ONEHOT_MAX_W) r[idx[4:0]] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/scan_decoder_dwell_counter.sv
// dwell_counter: counts enabled clocks from 0, done while count == TC-1.
//   clk  in  clock, rising edge
//   rst  in  synchronous reset, active-high
//   clr  in  synchronous clear to 0 (wins over en)
//   en   in  increment
//   done out count has reached TC-1 (combinational from the count register)
module dwell_counter #(
  parameter int TC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int W = $clog2(TC + 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) cnt_q <= '0;
    else if (en)    cnt_q <= cnt_q + 1'b1;
  end

  assign done = (cnt_q == W'(TC - 1));

endmodule

// File: rtl/scan_decoder.sv
// scan_decoder: registered SEL_W-to-NUM_OUT decoder, active-low one-hot outputs.
// Direct mode decodes sel; scan mode walks indices 0..NUM_OUT-1, each held DWELL clocks.
//   clk     in   clock, rising edge
//   rst     in   synchronous reset, active-high
//   e       in   disable, active-high (forces all outputs off)
//   mode    in   0 = direct decode, 1 = auto-scan
//   sel     in   index decoded in direct mode
//   y       out  active-low one-hot outputs (registered)
//   cur_idx out  index being driven, or last index driven
//   wrap    out  1-clock pulse when the scan returns from NUM_OUT-1 to 0
// Optional macro SCAN_DECODER_BLANK_EN: inserts BLANK all-off clocks between scan steps.
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int SEL_W   = 2,
  parameter int NUM_OUT = 2**SEL_W,
  parameter int DWELL   = 4,
  parameter int BLANK   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               e,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  output logic [NUM_OUT-1:0] y,
  output logic [SEL_W-1:0]   cur_idx,
  output logic               wrap
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_OUT - 1);

  state_e             state_q, state_d;
  logic [NUM_OUT-1:0] y_q, y_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic               wrap_q, wrap_d;

  logic dwell_clr, dwell_en, dwell_done;

  logic [ONEHOT_MAX_W-1:0] oh_sel, oh_nxt;
  logic [SEL_W-1:0]        idx_nxt;
  logic                    sel_ok;
  logic                    unused_oh;

  // Scan step wraps modulo NUM_OUT, not 2**SEL_W.
  assign idx_nxt   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
  assign oh_sel    = onehot_n(32'(sel), NUM_OUT);
  assign oh_nxt    = onehot_n(32'(idx_nxt), NUM_OUT);
  assign sel_ok    = ~&oh_sel[NUM_OUT-1:0];
  assign unused_oh = ^{oh_sel, oh_nxt};

  dwell_counter #(.TC(DWELL)) u_dwell (
    .clk  (clk),
    .rst  (rst),
    .clr  (dwell_clr),
    .en   (dwell_en),
    .done (dwell_done)
  );

`ifdef SCAN_DECODER_BLANK_EN
  logic blank_clr, blank_en, blank_done;

  dwell_counter #(.TC(BLANK)) u_blank (
    .clk  (clk),
    .rst  (rst),
    .clr  (blank_clr),
    .en   (blank_en),
    .done (blank_done)
  );
`else
  logic unused_blank;
  assign unused_blank = (BLANK > 0);
`endif

  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    idx_d     = idx_q;
    wrap_d    = 1'b0;
    dwell_en  = 1'b0;
    dwell_clr = 1'b1;
`ifdef SCAN_DECODER_BLANK_EN
    blank_en  = 1'b0;
    blank_clr = 1'b1;
`endif
    if (e) begin
      state_d = ST_OFF;
      y_d     = '1;
    end else if (!mode) begin
      state_d = ST_DIRECT;
      y_d     = oh_sel[NUM_OUT-1:0];
      if (sel_ok) idx_d = sel;
    end else begin
      case (state_q)
        ST_SCAN_HOLD: begin
          if (!dwell_done) begin
            dwell_en  = 1'b1;
            dwell_clr = 1'b0;
          end else begin
`ifdef SCAN_DECODER_BLANK_EN
            state_d = ST_SCAN_BLANK;
            y_d     = '1;
`else
            y_d     = oh_nxt[NUM_OUT-1:0];
            idx_d   = idx_nxt;
            wrap_d  = (idx_q == LAST_IDX);
`endif
          end
        end
`ifdef SCAN_DECODER_BLANK_EN
        ST_SCAN_BLANK: begin
          if (!blank_done) begin
            blank_en  = 1'b1;
            blank_clr = 1'b0;
          end else begin
            state_d = ST_SCAN_HOLD;
            y_d     = oh_nxt[NUM_OUT-1:0];
            idx_d   = idx_nxt;
            wrap_d  = (idx_q == LAST_IDX);
          end
        end
`endif
        // Entry from OFF/DIRECT: restart at index 0, never flag a wrap.
        default: begin
          state_d = ST_SCAN_HOLD;
          y_d     = {{(NUM_OUT-1){1'b1}}, 1'b0};
          idx_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OFF;
      y_q     <= '1;
      idx_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
      wrap_q  <= wrap_d;
    end
  end

  assign y       = y_q;
  assign cur_idx = idx_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// tb_scan_decoder: directed plus random stimulus on two decoder instances
// (4 outputs / DWELL 3, and 3 outputs / DWELL 1), compared every clock
// against a scan-position model computed from elapsed scan time.
module tb_scan_decoder;

`ifdef SCAN_DECODER_BLANK_EN
  localparam int BLK = 1;
`else
  localparam int BLK = 0;
`endif

  logic       clk;
  logic       rst, e, mode;
  logic [1:0] sel;
  logic [3:0] y4;
  logic [2:0] y3;
  logic [1:0] idx4, idx3;
  logic       wrap4, wrap3;

  int n_chk = 0;
  int n_err = 0;

  scan_decoder #(.SEL_W(2), .NUM_OUT(4), .DWELL(3), .BLANK(1)) dut4 (
    .clk(clk), .rst(rst), .e(e), .mode(mode), .sel(sel),
    .y(y4), .cur_idx(idx4), .wrap(wrap4)
  );

  scan_decoder #(.SEL_W(2), .NUM_OUT(3), .DWELL(1), .BLANK(1)) dut3 (
    .clk(clk), .rst(rst), .e(e), .mode(mode), .sel(sel),
    .y(y3), .cur_idx(idx3), .wrap(wrap3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit scan;
    int t;
    int idx;
    int y;
    bit wrap;
  } mdl_t;

  mdl_t m4, m3;

  // Scan output derived from time since scan start: step = t / period.
  function automatic mdl_t mstep(mdl_t m, int n, int dwell, bit r, bit dis, bit md, int s);
    int all, per, step, ph;
    all    = (1 << n) - 1;
    m.wrap = 1'b0;
    if (r) begin
      m.scan = 0; m.t = 0; m.idx = 0; m.y = all;
    end else if (dis) begin
      m.scan = 0; m.y = all;
    end else if (!md) begin
      m.scan = 0;
      if (s < n) begin m.idx = s; m.y = all & ~(1 << s); end
      else m.y = all;
    end else begin
      if (!m.scan) begin m.scan = 1; m.t = 0; end
      else m.t++;
      per  = dwell + BLK;
      step = m.t / per;
      ph   = m.t % per;
      m.idx = step % n;
      if (ph < dwell) begin
        m.y    = all & ~(1 << m.idx);
        m.wrap = (ph == 0 && step > 0 && m.idx == 0);
      end else begin
        m.y = all;
      end
    end
    return m;
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic tick(input bit r, input bit dis, input bit md, input int s);
    rst = r; e = dis; mode = md; sel = 2'(s);
    @(posedge clk);
    #1;
    m4 = mstep(m4, 4, 3, r, dis, md, s);
    m3 = mstep(m3, 3, 1, r, dis, md, s);
    chk("y4",    int'(y4),    m4.y);
    chk("idx4",  int'(idx4),  m4.idx);
    chk("wrap4", int'(wrap4), int'(m4.wrap));
    chk("y3",    int'(y3),    m3.y);
    chk("idx3",  int'(idx3),  m3.idx);
    chk("wrap3", int'(wrap3), int'(m3.wrap));
  endtask

  initial begin
    m4 = '{scan: 0, t: 0, idx: 0, y: 15, wrap: 0};
    m3 = '{scan: 0, t: 0, idx: 0, y: 7,  wrap: 0};
    rst = 1'b1; e = 1'b1; mode = 1'b0; sel = 2'd0;

    // Reset then disabled.
    tick(1, 1, 0, 0); tick(1, 1, 0, 0);
    chk("rst_y4", int'(y4), 15);
    tick(0, 1, 0, 0); tick(0, 1, 0, 0);

    // Direct decode of every sel, then disable (index must hold).
    for (int s = 0; s < 4; s++) tick(0, 0, 0, s);
    tick(0, 1, 0, 0);

    // Full scan cycle through the wrap.
    for (int i = 0; i < 16; i++) tick(0, 0, 1, 0);

    // Disable pulse mid-scan, then restart.
    tick(0, 0, 0, 0);
    for (int i = 0; i < 7; i++) tick(0, 0, 1, 0);
    tick(0, 1, 1, 0);
    for (int i = 0; i < 6; i++) tick(0, 0, 1, 0);

    // Reset mid-scan.
    tick(1, 0, 1, 2);
    for (int i = 0; i < 5; i++) tick(0, 0, 1, 1);

    // Scan -> direct -> scan.
    tick(0, 0, 0, 3); tick(0, 0, 0, 2);
    for (int i = 0; i < 4; i++) tick(0, 0, 1, 0);

    // Random: long scan runs with occasional disable, reset and mode flips.
    begin
      bit md = 1'b1;
      for (int i = 0; i < 800; i++) begin
        bit r, dis;
        r   = ($urandom_range(0, 59) == 0);
        dis = ($urandom_range(0, 24) == 0);
        if ($urandom_range(0, 29) == 0) md = ~md;
        tick(r, dis, md, int'($urandom_range(0, 3)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
